// File: rtl/gpio_input_debounce.sv
// gpio_input_debounce: synchronises and debounces the board switch/key inputs
// before they reach the SoC GPIO input bus.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   reset       synchronous active-high reset
//   raw_i       asynchronous board pins {SW, KEY}
//   level_o     debounced, polarity-corrected level
//   rise_o      one-cycle pulse after level_o goes 0->1
//   fall_o      one-cycle pulse after level_o goes 1->0
//   evt_mask_i  per-bit event enable for irq_o
//   evt_clr_i   write-1-to-clear for evt_o
//   evt_o       sticky edge-event flags
//   irq_o       OR of (evt_o & evt_mask_i)
//
// Build option: define GPIO_INPUT_EDGE_EVT_EN to implement the edge pulses,
// sticky events and interrupt. Without it those outputs are tied low and no
// edge/event flops exist.
module gpio_input_debounce #(
  parameter int unsigned W              = 22,
  parameter int unsigned TICK_CYCLES    = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 10,
  parameter logic [W-1:0] RESET_LEVEL   = W'(4'hF),
  parameter logic [W-1:0] INVERT_MASK   = W'(4'hF)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] level_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o,
  input  logic [W-1:0] evt_mask_i,
  input  logic [W-1:0] evt_clr_i,
  output logic [W-1:0] evt_o,
  output logic         irq_o
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  // One spare bit so the counter can hold DEBOUNCE_TICKS-1 for any value.
  localparam int unsigned CW = $clog2(DEBOUNCE_TICKS) + 1;
  localparam logic [PW-1:0] PresLast = PW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] CntLast  = CW'(DEBOUNCE_TICKS - 1);

  logic [W-1:0]         sync1_q, sync2_q;
  logic [W-1:0]         stable_q, stable_d;
  logic [W-1:0][CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;
  logic [W-1:0]         level;

  assign tick    = (presc_q == PresLast);
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Each bit needs DEBOUNCE_TICKS consecutive disagreeing tick samples;
  // a single agreeing sample restarts its qualification.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (tick) begin
      for (int i = 0; i < int'(W); i++) begin
        if (sync2_q[i] != stable_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= RESET_LEVEL;
      sync2_q  <= RESET_LEVEL;
      stable_q <= RESET_LEVEL;
      cnt_q    <= '0;
      presc_q  <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
    end
  end

  // XOR with a constant adds no register stage beyond stable_q.
  assign level   = stable_q ^ INVERT_MASK;
  assign level_o = level;

`ifdef GPIO_INPUT_EDGE_EVT_EN
  logic [W-1:0] level_prev_q;
  logic [W-1:0] rise_q, fall_q;
  logic [W-1:0] evt_q, evt_d;

  // New edges set the flag even when a clear arrives in the same cycle.
  assign evt_d = (evt_q & ~evt_clr_i) | rise_q | fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Matches the post-reset level so no pulse follows reset release.
      level_prev_q <= RESET_LEVEL ^ INVERT_MASK;
      rise_q       <= '0;
      fall_q       <= '0;
      evt_q        <= '0;
    end else begin
      level_prev_q <= level;
      rise_q       <= level & ~level_prev_q;
      fall_q       <= ~level & level_prev_q;
      evt_q        <= evt_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign evt_o  = evt_q;
  assign irq_o  = |(evt_q & evt_mask_i);
`else
  logic unused_evt_inputs;
  assign unused_evt_inputs = ^{evt_mask_i, evt_clr_i};

  assign rise_o = '0;
  assign fall_o = '0;
  assign evt_o  = '0;
  assign irq_o  = 1'b0;
`endif

endmodule
